// File: rtl/esram_copy_pkg.sv
// Shared state encoding and TL-UL request constants for the ESRAM copy controller.
package esram_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RSP,
    WR_REQ,
    WR_RSP,
    DONE
  } state_e;

  localparam logic [2:0] OpGet           = 3'h4;
  localparam logic [2:0] OpPutFullData   = 3'h0;
  localparam logic [1:0] SizeWord        = 2'd2;
  localparam logic [3:0] MaskWord        = 4'hF;
  localparam logic [7:0] DefaultSourceId = 8'h10;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types for this slice, plus the encoder used for a_user integrity.
package tlul_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned IntgW = 7;

  localparam logic [3:0] MuBi4False = 4'h9;

  typedef struct packed {
    logic [3:0]       instr_type;
    logic [IntgW-1:0] cmd_intg;
    logic [IntgW-1:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic               a_valid;
    logic [2:0]         a_opcode;
    logic [2:0]         a_param;
    logic [1:0]         a_size;
    logic [7:0]         a_source;
    logic [AddrW-1:0]   a_address;
    logic [DataW/8-1:0] a_mask;
    logic [DataW-1:0]   a_data;
    tl_a_user_t         a_user;
    logic               d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [1:0]       d_size;
    logic [7:0]       d_source;
    logic [DataW-1:0] d_data;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

  // Each check bit is the inverted parity over one mask; inversion keeps all-zero payloads non-zero.
  localparam logic [IntgW-1:0][63:0] IntgMask = {
    64'h01FF_FFFF_FFFF_E000,
    64'h01FF_FC00_0000_1000,
    64'h0000_03FF_F800_0FFF,
    64'h01FC_03F8_07F0_0FE0,
    64'h01E3_C3C7_878F_0F1E,
    64'h019B_3336_6667_CCCD,
    64'h0156_AAAD_5556_AAAB
  };

  function automatic logic [IntgW-1:0] intg_enc(input logic [63:0] d);
    logic [IntgW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(IntgW); i++) begin
      p[i] = ~^(d & IntgMask[i]);
    end
    return p;
  endfunction

endpackage

// File: rtl/esram_copy_ctrl_if.sv
// TL-UL host/device channel pair bundled for connecting the copy controller to a device.
interface esram_copy_ctrl_if;
  import tlul_pkg::*;

  tl_h2d_t h2d;
  tl_d2h_t d2h;

  modport master (output h2d, input d2h);
  modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_cmd_intg_gen.sv
// Fills a_user command and data integrity on an outgoing TL-UL request; all other fields pass through.
module tlul_cmd_intg_gen
  import tlul_pkg::*;
(
  input  tl_h2d_t tl_i,
  output tl_h2d_t tl_o
);

  logic unused_intg;

  always_comb begin
    tl_o                  = tl_i;
    tl_o.a_user.cmd_intg  = intg_enc(64'({tl_i.a_user.instr_type, tl_i.a_address,
                                          tl_i.a_opcode, tl_i.a_mask}));
    tl_o.a_user.data_intg = intg_enc(64'(tl_i.a_data));
  end

  assign unused_intg = ^{tl_i.a_user.cmd_intg, tl_i.a_user.data_intg};

endmodule

// File: rtl/esram_copy_ctrl.sv
// Copies len 32-bit words from src to dst over TL-UL, one Get then one PutFullData per word,
// with a single outstanding transaction; stops at the first error response.
module esram_copy_ctrl
  import esram_copy_pkg::*;
  import tlul_pkg::*;
#(
  parameter logic [7:0]  SourceId = DefaultSourceId,
  parameter int unsigned LenW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AddrW-1:0] src_addr_i,
  input  logic [AddrW-1:0] dst_addr_i,
  input  logic [LenW-1:0]  len_words_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LenW-1:0]  words_done_o,
  output tl_h2d_t          tl_o,
  input  tl_d2h_t          tl_i
);

  state_e           state_q, state_d;
  logic [AddrW-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic [LenW-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             a_valid_q, a_valid_d, d_ready_q, d_ready_d, put_q, put_d;
  logic             misaligned_c;
  tl_h2d_t          tl_pre;
  logic             unused_tl;

  assign misaligned_c = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

  // Next state, datapath updates, and next values of every registered output.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_words_i;
          cnt_d   = '0;
          err_d   = misaligned_c;
          state_d = (misaligned_c || (len_words_i == '0)) ? DONE : RD_REQ;
        end
      end
      RD_REQ: if (tl_i.a_ready) state_d = RD_RSP;
      RD_RSP: begin
        if (tl_i.d_valid) begin
          data_d = tl_i.d_data;
          if (tl_i.d_error) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: if (tl_i.a_ready) state_d = WR_RSP;
      WR_RSP: begin
        if (tl_i.d_valid) begin
          if (tl_i.d_error) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + LenW'(1);
            src_d   = src_q + AddrW'(4);
            dst_d   = dst_q + AddrW'(4);
            state_d = (cnt_d == len_q) ? DONE : RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    a_valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    d_ready_d = (state_d == RD_RSP) || (state_d == WR_RSP);
    put_d     = (state_d == WR_REQ);
    addr_d    = (state_d == WR_REQ) ? dst_d : src_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      a_valid_q <= 1'b0;
      d_ready_q <= 1'b0;
      put_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      a_valid_q <= a_valid_d;
      d_ready_q <= d_ready_d;
      put_q     <= put_d;
    end
  end

  // A-channel payload is built only from registers, so it holds steady while a_ready is low.
  always_comb begin
    tl_pre                   = '0;
    tl_pre.a_valid           = a_valid_q;
    tl_pre.a_opcode          = put_q ? OpPutFullData : OpGet;
    tl_pre.a_param           = 3'h0;
    tl_pre.a_size            = SizeWord;
    tl_pre.a_source          = SourceId;
    tl_pre.a_address         = addr_q;
    tl_pre.a_mask            = MaskWord;
    tl_pre.a_data            = put_q ? data_q : '0;
    tl_pre.a_user.instr_type = MuBi4False;
    tl_pre.d_ready           = d_ready_q;
  end

  tlul_cmd_intg_gen u_intg_gen (
    .tl_i (tl_pre),
    .tl_o (tl_o)
  );

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_done_o = cnt_q;

  assign unused_tl = ^{tl_i.d_opcode, tl_i.d_size, tl_i.d_source};

endmodule
